// File: rtl/fila_busca_instrucao_pkg.sv
// ---------------------------------------------------------------------------
// fila_busca_instrucao_pkg
//   Definitions shared by the instruction fetch queue:
//   - FSM state encoding: BUSCA is normal fetch. DRENO discards responses that
//     belong to requests issued before a flush.
//   - Instruction word width and the opcode field position in the
//     ooo xxx yyy zzz/imm format.
// ---------------------------------------------------------------------------
package fila_busca_instrucao_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;

  // FSM states are kept as plain constants so older tools can read them.
  localparam logic [0:0] BUSCA = 1'b0;
  localparam logic [0:0] DRENO = 1'b1;

  typedef logic [INSTR_W-1:0] instr_t;

  // Field view of an instruction word: opcode followed by the operand bits.
  typedef struct packed {
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic [OPCODE_LSB-1:0]          operands;
  } instr_fields_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input instr_t word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fila_busca_mem.sv
// ---------------------------------------------------------------------------
// fila_busca_mem
//   Storage for the fetch queue: a DEPTH x 16 register array with one
//   synchronous write port and one asynchronous read port.
//   Ports:
//     clock    - rising-edge clock
//     wr_en    - write enable
//     wr_ptr   - write index (queue tail)
//     wr_data  - word to store
//     rd_ptr   - read index (queue head)
//     rd_data  - word at rd_ptr (combinational)
// ---------------------------------------------------------------------------
module fila_busca_mem
  import fila_busca_instrucao_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_ptr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic [PTR_W-1:0]   rd_ptr,
  output logic [INSTR_W-1:0] rd_data
);

  instr_t mem [DEPTH];

  // NOTE: the array has no reset. Whether an entry is valid is tracked by the
  // occupancy count in the controller, so clearing the storage would only add
  // reset fan-out without changing behaviour.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fila_busca_instrucao.sv
// ---------------------------------------------------------------------------
// fila_busca_instrucao
//   Instruction fetch queue. The queue issues in-order requests to the
//   instruction memory. Returned words go into a DEPTH-entry FIFO. The issue
//   stage reads the head entry and pops it with despacho.
//   A request is issued only when the queue has room for it: the request
//   condition requires count + pend < DEPTH. Because every outstanding
//   response already has a reserved slot, the queue never overflows.
//   A flush discards the queue and restarts fetch at flush_pc. Responses that
//   are still in flight are dropped in state DRENO.
//
//   Ports:
//     clock, reset_n      - clock and asynchronous active-low reset
//     despacho            - pop the head entry (ignored when the queue is empty)
//     flush, flush_pc     - discard the queue and restart fetch at flush_pc
//     mem_req, mem_addr   - one-cycle fetch request and its address
//     mem_ack, mem_rdata  - in-order response and its instruction word
//     instrucao           - head instruction, 16'h0000 when the queue is empty
//     instr_valida        - instrucao holds a valid instruction
//
//   Configuration macro FILA_BYPASS_EN: when defined, a response that arrives
//   while the queue is empty is presented on instrucao in the same cycle.
// ---------------------------------------------------------------------------
module fila_busca_instrucao
  import fila_busca_instrucao_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADDR_W   = 8,
  parameter int MAX_PEND = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               despacho,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_pc,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instrucao,
  output logic               instr_valida
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [0:0]        state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  count, pend, pend_next;
  logic [PTR_W-1:0]  head, tail;
  logic              empty, credit_ok, push, pop;
  instr_t            head_word;

  assign empty    = (count == '0);
  assign mem_addr = pc;

  // The sum is computed one bit wider so that it cannot wrap before the compare.
  assign credit_ok = ({1'b0, count} + {1'b0, pend} < SUM_W'(DEPTH)) &&
                     (pend < CNT_W'(MAX_PEND));

  // Reset gates the request directly. Otherwise the reset state (BUSCA, empty,
  // nothing pending) would already request while reset_n is still low.
  assign mem_req = reset_n && (state == BUSCA) && !flush && credit_ok;

`ifdef FILA_BYPASS_EN
  logic bypass;

  // A response for an empty queue goes straight to the output. If it is
  // dispatched in the same cycle, it is never written into the queue.
  assign bypass       = reset_n && (state == BUSCA) && mem_ack && empty && !flush;
  assign push         = (state == BUSCA) && mem_ack && !flush && !(bypass && despacho);
  assign instr_valida = !empty || bypass;
  assign instrucao    = !empty ? head_word : (bypass ? mem_rdata : '0);
`else
  assign push         = (state == BUSCA) && mem_ack && !flush;
  assign instr_valida = !empty;
  assign instrucao    = empty ? '0 : head_word;
`endif

  // A pop needs a registered entry. A word taken over the bypass path was
  // never stored, so it does not move the head pointer.
  assign pop = despacho && !empty && !flush;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    pend_next  = pend;
    state_next = state;

    // A response with nothing outstanding belongs to the environment, not to
    // this queue. Guarding the decrement keeps pend from wrapping.
    if (mem_req && !(mem_ack && pend != '0))
      pend_next = pend + CNT_W'(1);
    else if (!mem_req && mem_ack && pend != '0)
      pend_next = pend - CNT_W'(1);

    if (flush)
      state_next = (pend_next != '0) ? DRENO : BUSCA;
    else if (state == DRENO && pend_next == '0)
      state_next = BUSCA;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= BUSCA;
      pc    <= '0;
      count <= '0;
      pend  <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      pend  <= pend_next;

      if (flush) begin
        pc    <= flush_pc;
        count <= '0;
        head  <= '0;
        tail  <= '0;
      end else begin
        if (mem_req) pc   <= pc + ADDR_W'(1);
        if (push)    tail <= tail + PTR_W'(1);
        if (pop)     head <= head + PTR_W'(1);

        // A push and a pop in the same cycle cancel and leave count unchanged.
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  fila_busca_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clock   (clock),
    .wr_en   (push),
    .wr_ptr  (tail),
    .wr_data (mem_rdata),
    .rd_ptr  (head),
    .rd_data (head_word)
  );

endmodule

// File: tb/tb_fila_busca_instrucao.sv
// ---------------------------------------------------------------------------
// tb_fila_busca_instrucao
//   Directed bench for fila_busca_instrucao with its default parameters
//   (DEPTH=4, ADDR_W=8, MAX_PEND=2). A small memory model answers each
//   request in the following cycle while ack_en is set. Inputs are driven
//   on the falling edge, and outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_fila_busca_instrucao;
  import fila_busca_instrucao_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        despacho = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  flush_pc = 8'h00;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instrucao;
  logic        instr_valida;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem_img [256];
  logic [7:0]  pend_q [$];
  bit          ack_en = 1'b0;

  // Values observed during the most recent step.
  logic        obs_req;
  logic [7:0]  obs_addr;
  logic        obs_valid;
  logic [15:0] obs_instr;

  fila_busca_instrucao dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .despacho     (despacho),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .instrucao    (instrucao),
    .instr_valida (instr_valida)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] word_of(input int a);
    return {8'(a), 8'(a) ^ 8'h3C};
  endfunction

  // Call this at a falling edge, after the caller has set despacho and flush.
  task automatic step();
    if (ack_en && pend_q.size() > 0) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_img[pend_q.pop_front()];
    end else begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
    end
    #1;
    obs_req   = mem_req;
    obs_addr  = mem_addr;
    obs_valid = instr_valida;
    obs_instr = instrucao;
    if (mem_req) pend_q.push_back(mem_addr);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset_n  = 1'b0;
    despacho = 1'b0;
    flush    = 1'b0;
    mem_ack  = 1'b0;
    ack_en   = 1'b0;
    pend_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
    n_cmp++; if (instr_valida !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valida); end
    n_cmp++; if (instrucao !== 16'h0000) begin n_bad++; $display("FAIL reset_instr: got %h want 0000", instrucao); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Latency 1 and no despacho: requests go out at addresses 0..3, then stop while the queue is full.
  task automatic test_fill();
    bit exp_req [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    ack_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_cmp++; if (obs_req !== exp_req[i]) begin n_bad++; $display("FAIL fill_req[%0d]: got %b want %b", i, obs_req, exp_req[i]); end
      if (exp_req[i]) begin
        n_cmp++; if (obs_addr !== 8'(i)) begin n_bad++; $display("FAIL fill_addr[%0d]: got %h want %h", i, obs_addr, 8'(i)); end
      end
`ifndef FILA_BYPASS_EN
      if (i == 1) begin
        n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL fill_latency: got %b want 0", obs_valid); end
      end
`endif
      if (i >= 2) begin
        n_cmp++; if (obs_instr !== word_of(0)) begin n_bad++; $display("FAIL fill_head[%0d]: got %h want %h", i, obs_instr, word_of(0)); end
      end
    end
  endtask

  // The queue is full. Reset must clear the outputs immediately.
  task automatic test_reset_mid();
    reset_n = 1'b0;
    ack_en  = 1'b0;
    pend_q.delete();
    #1;
    n_cmp++; if (instr_valida !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", instr_valida); end
    n_cmp++; if (instrucao !== 16'h0000) begin n_bad++; $display("FAIL rstmid_instr: got %h want 0000", instrucao); end
    n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_req: got %b want 0", mem_req); end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin n_bad++; $display("FAIL rstmid_restart: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr); end
    n_cmp++; if (instr_valida !== 1'b0) begin n_bad++; $display("FAIL rstmid_empty: got %b want 0", instr_valida); end
    @(negedge clock);
  endtask

  // The queue holds 2A05 and 4C80 with two requests outstanding. despacho is held at 1.
  task automatic test_drain();
    apply_reset();
    mem_img[0] = 16'h2A05;
    mem_img[1] = 16'h4C80;
    ack_en = 1'b1;
    repeat (3) step();
    ack_en = 1'b0;
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 8'h03) begin n_bad++; $display("FAIL drain_req3: got req=%b addr=%h want req=1 addr=03", obs_req, obs_addr); end
    step();
    n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL drain_maxpend: got %b want 0", obs_req); end
    despacho = 1'b1;
    step();
    n_cmp++; if (obs_valid !== 1'b1 || obs_instr !== 16'h2A05) begin n_bad++; $display("FAIL drain_first: got v=%b %h want v=1 2a05", obs_valid, obs_instr); end
    step();
    n_cmp++; if (obs_valid !== 1'b1 || obs_instr !== 16'h4C80) begin n_bad++; $display("FAIL drain_second: got v=%b %h want v=1 4c80", obs_valid, obs_instr); end
    step();
    n_cmp++; if (obs_valid !== 1'b0 || obs_instr !== 16'h0000) begin n_bad++; $display("FAIL drain_empty: got v=%b %h want v=0 0000", obs_valid, obs_instr); end
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL drain_ignored_pop: got %b want 0", obs_valid); end
    despacho = 1'b0;
  endtask

  // Continues from test_drain: addresses 2 and 3 are still outstanding when the flush to 40 happens.
  task automatic test_flush_drain();
    flush    = 1'b1;
    flush_pc = 8'h40;
    step();
    n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL flush_req: got %b want 0", obs_req); end
    flush = 1'b0;
    n_cmp++; if (dut.state !== DRENO) begin n_bad++; $display("FAIL flush_state: got %b want %b", dut.state, DRENO); end
    ack_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin n_bad++; $display("FAIL dreno_drop[%0d]: got req=%b v=%b want 0 0", i, obs_req, obs_valid); end
    end
    n_cmp++; if (dut.state !== BUSCA) begin n_bad++; $display("FAIL dreno_exit: got %b want %b", dut.state, BUSCA); end
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 8'h40) begin n_bad++; $display("FAIL flush_restart: got req=%b addr=%h want 1 40", obs_req, obs_addr); end
  endtask

  // With count=3, a pop and a push in the same cycle must keep count and the word order.
  task automatic test_pop_push();
    repeat (3) step();
    despacho = 1'b1;
    step();
    n_cmp++; if (obs_instr !== word_of(8'h40) || obs_req !== 1'b0) begin n_bad++; $display("FAIL popush_head: got %h req=%b want %h req=0", obs_instr, obs_req, word_of(8'h40)); end
    despacho = 1'b0;
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 8'h44) begin n_bad++; $display("FAIL popush_credit: got req=%b addr=%h want 1 44", obs_req, obs_addr); end
    n_cmp++; if (obs_instr !== word_of(8'h41)) begin n_bad++; $display("FAIL popush_next: got %h want %h", obs_instr, word_of(8'h41)); end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (obs_req !== 1'b0) begin n_bad++; $display("FAIL popush_full[%0d]: got %b want 0", i, obs_req); end
    end
    ack_en   = 1'b0;
    despacho = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (obs_valid !== 1'b1 || obs_instr !== word_of(8'h41 + i)) begin n_bad++; $display("FAIL popush_order[%0d]: got v=%b %h want v=1 %h", i, obs_valid, obs_instr, word_of(8'h41 + i)); end
    end
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL popush_empty: got %b want 0", obs_valid); end
    despacho = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    flush    = 1'b1;
    flush_pc = 8'hFF;
    step();
    flush  = 1'b0;
    ack_en = 1'b1;
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 8'hFF) begin n_bad++; $display("FAIL wrap_ff: got req=%b addr=%h want 1 ff", obs_req, obs_addr); end
    step();
    n_cmp++; if (obs_req !== 1'b1 || obs_addr !== 8'h00) begin n_bad++; $display("FAIL wrap_00: got req=%b addr=%h want 1 00", obs_req, obs_addr); end
  endtask

`ifdef FILA_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    mem_img[0] = 16'hA123;
    ack_en = 1'b1;
    step();
    despacho = 1'b1;
    step();
    n_cmp++; if (obs_valid !== 1'b1 || obs_instr !== 16'hA123) begin n_bad++; $display("FAIL bypass_word: got v=%b %h want v=1 a123", obs_valid, obs_instr); end
    despacho = 1'b0;
    ack_en   = 1'b0;
    step();
    n_cmp++; if (obs_valid !== 1'b0) begin n_bad++; $display("FAIL bypass_nowrite: got %b want 0", obs_valid); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem_img[i] = word_of(i);
    test_reset();
    test_fill();
    test_reset_mid();
    test_drain();
    test_flush_drain();
    test_pop_push();
    test_wrap();
`ifdef FILA_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
